// File: rtl/vsweep_pkg.sv
// Shared types and parameter-legality limits for the exhaustive vector sweeper.
package vsweep_pkg;

  localparam int unsigned N_IN_MAX = 8;
  localparam int unsigned HOLD_MIN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/sweep_hold_counter.sv
// Per-vector hold counter; pulses are registered from the next count so they
// line up with the edge on which the count equals SETTLE / HOLD-1.
module sweep_hold_counter #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic sample_pulse_o,
  output logic last_pulse_o
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample_q, last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == CW'(HOLD - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sample_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sample_q <= (cnt_d == CW'(SETTLE));
      last_q   <= (cnt_d == CW'(HOLD - 1));
    end
  end

  assign sample_pulse_o = sample_q;
  assign last_pulse_o   = last_q;

endmodule

// File: rtl/exhaustive_vector_sweep.sv
// Walks all 2^N_IN input vectors onto a combinational unit, samples F once per
// vector and scores it against a truth table latched at START.
module exhaustive_vector_sweep
  import vsweep_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [(1<<N_IN)-1:0]   expect_i,
  input  logic                   f_i,
  output logic [N_IN-1:0]        vec_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [N_IN:0]          err_count_o,
  output logic                   fail_valid_o,
  output logic [N_IN-1:0]        first_fail_o
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned EW = N_IN + 1;

  state_e          state_q, state_d;
  logic [NV-1:0]   expect_q, expect_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic [EW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            clear_c;
  logic            sample_pulse, last_pulse;

  sweep_hold_counter #(
    .HOLD   (HOLD),
    .SETTLE (SETTLE)
  ) u_hold (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (clear_c),
    .enable_i       (state_q == RUN),
    .sample_pulse_o (sample_pulse),
    .last_pulse_o   (last_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      expect_q <= '0;
      vec_q    <= '0;
      ff_q     <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      vec_q    <= vec_d;
      ff_q     <= ff_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Sampling is scored before the vector step so PASS sees the final count
  // even when SETTLE == HOLD-1 puts both on the same edge.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    vec_d    = vec_q;
    ff_d     = ff_q;
    err_d    = err_q;
    fv_d     = fv_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    clear_c  = 1'b0;

    case (state_q)
      IDLE, FINISH: begin
        if (start_i) begin
          state_d  = RUN;
          expect_d = expect_i;
          vec_d    = '0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          clear_c  = 1'b1;
        end
      end
      RUN: begin
        if (sample_pulse && (f_i != expect_q[vec_q])) begin
          err_d = err_q + EW'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        if (last_pulse) begin
          if (vec_q == '1) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
      vec_d   = '0;
      err_d   = '0;
      fv_d    = 1'b0;
      ff_d    = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      clear_c = 1'b1;
    end
  end

  assign vec_o        = vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign fail_valid_o = fv_q;
  assign first_fail_o = ff_q;

endmodule

// File: tb/tb_exhaustive_vector_sweep.sv
// Scoreboard bench for exhaustive_vector_sweep at N_IN=3, HOLD=4, SETTLE=2.
module tb_exhaustive_vector_sweep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic [7:0] expect_i;
  logic       f_i;
  logic [2:0] vec_o;
  logic       busy_o, done_o, pass_o, fail_valid_o;
  logic [3:0] err_count_o;
  logic [2:0] first_fail_o;
  int         f_mode;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] err;
    logic       fv;
    logic [2:0] ff;
    logic       pass;
  } res_t;

  res_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  assign f_i = (f_mode == 0) ? maj3(vec_o) : 1'b0;

  exhaustive_vector_sweep #(.N_IN(3), .HOLD(4), .SETTLE(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .expect_i     (expect_i),
    .f_i          (f_i),
    .vec_o        (vec_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .err_count_o  (err_count_o),
    .fail_valid_o (fail_valid_o),
    .first_fail_o (first_fail_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [7:0] e, input int fm);
    res_t r;
    logic fv;
    r.err = '0; r.fv = 1'b0; r.ff = '0;
    for (int v = 0; v < 8; v++) begin
      fv = (fm == 0) ? maj3(3'(v)) : 1'b0;
      if (e[v] != fv) begin
        r.err = r.err + 4'd1;
        if (!r.fv) begin
          r.fv = 1'b1;
          r.ff = 3'(v);
        end
      end
    end
    r.pass = (r.err == 4'd0);
    return r;
  endfunction

  // Drives one sweep; optional re-START, ABORT or async reset at a given clock.
  task automatic run_sweep(input logic [7:0] e, input int fm, input int repulse_at,
                           input int abort_at, input int reset_at);
    int   done_cyc;
    res_t r;
    expect_i = e;
    f_mode   = fm;
    if (abort_at < 0 && reset_at < 0) sb_q.push_back(model(e, fm));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("start_busy", 32'(busy_o), 32'd1);
    check_eq("start_vec",  32'(vec_o),  32'd0);
    check_eq("start_done", 32'(done_o), 32'd0);
    done_cyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start_i = (cyc == repulse_at);
      abort_i = (cyc == abort_at);
      if (cyc == repulse_at) expect_i = ~e;
      tick();
      start_i = 1'b0;
      if (cyc == abort_at) begin
        abort_i = 1'b0;
        check_eq("abort_state", {28'd0, busy_o, done_o, pass_o, fail_valid_o}, 32'd0);
        check_eq("abort_vec",   32'(vec_o), 32'd0);
        check_eq("abort_err",   32'(err_count_o), 32'd0);
        repeat (3) tick();
        check_eq("abort_quiet", {28'd0, busy_o, 3'(vec_o)}, 32'd0);
        return;
      end
      if (cyc == reset_at) begin
        check_eq("pre_rst_vec", 32'(vec_o), 32'd5);
        check_eq("pre_rst_err", 32'(err_count_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async", {18'd0, busy_o, done_o, pass_o, fail_valid_o,
                                err_count_o, first_fail_o, vec_o}, 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        check_eq("rst_quiet", {18'd0, busy_o, done_o, pass_o, fail_valid_o,
                                err_count_o, first_fail_o, vec_o}, 32'd0);
        return;
      end
      if (cyc < 32 && (cyc % 4) == 1) check_eq("vec_step", 32'(vec_o), 32'(cyc / 4));
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    check_eq("done_cycle", 32'(done_cyc), 32'd32);
    check_eq("end_busy",   32'(busy_o), 32'd0);
    check_eq("end_vec",    32'(vec_o),  32'd7);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      r = sb_q.pop_front();
      check_eq("err_count",  32'(err_count_o),  32'(r.err));
      check_eq("fail_valid", 32'(fail_valid_o), 32'(r.fv));
      check_eq("first_fail", 32'(first_fail_o), 32'(r.ff));
      check_eq("pass",       32'(pass_o),       32'(r.pass));
    end
    expect_i = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    expect_i = 8'hE8;
    f_mode   = 0;
    #12;
    check_eq("reset_out", {18'd0, busy_o, done_o, pass_o, fail_valid_o,
                            err_count_o, first_fail_o, vec_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_wait", {28'd0, busy_o, 3'(vec_o)}, 32'd0);

    run_sweep(8'hE8, 0, -1, -1, -1);   // majority unit, clean pass
    run_sweep(8'hE8, 1, -1, -1, -1);   // F stuck at 0
    run_sweep(8'hE8, 0, 10, -1, -1);   // START re-pulse ignored mid-run
    run_sweep(8'hE8, 0, -1, 13, -1);   // ABORT during vector 3
    run_sweep(8'hE8, 0, -1, -1, -1);   // full sweep after abort
    run_sweep(8'hE8, 1, -1, -1, 21);   // async reset at vector 5
    run_sweep(8'hE8, 1, -1, -1, -1);   // end in FINISH with PASS=0
    check_eq("finish_pass0", 32'(pass_o), 32'd0);
    run_sweep(8'h00, 1, -1, -1, -1);   // restart from FINISH, now passes

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
